// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared constants, loader FSM encoding and helpers for the CPU
//             program loader.
//  Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int c_MEM_SIZE_DEFAULT = 256;
    localparam int c_SYNC_STAGES      = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_SKIP = 2'd3
    } loader_state_t;

    // Byte counter increment that sticks at its maximum value.
    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sync_edge
//  Brief    : Multi-flop synchroniser with registered rise/fall detection.
//             o_LEVEL is delayed one stage so it lines up with the edge pulses.
//  Revision : 1.0
// ============================================================================
module cpu_sync_edge
    import cpu_pkg::*;
#(
    parameter int   STAGES  = c_SYNC_STAGES,
    parameter logic RST_VAL = 1'b0,
    parameter bit   EDGE_EN = 1'b1
) (
    input  logic i_CLK,
    input  logic i_RST_N,
    input  logic i_D,
    output logic o_LEVEL,
    output logic o_RISE,
    output logic o_FALL
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_sync <= {STAGES{RST_VAL}};
            r_dly  <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_D};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_LEVEL = r_dly;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_rise;
            logic r_fall;

            always_ff @(posedge i_CLK or negedge i_RST_N) begin
                if (!i_RST_N) begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= r_sync[STAGES-1] & ~r_dly;
                    r_fall <= ~r_sync[STAGES-1] & r_dly;
                end
            end

            assign o_RISE = r_rise;
            assign o_FALL = r_fall;
        end else begin : g_no_edge
            assign o_RISE = 1'b0;
            assign o_FALL = 1'b0;
        end
    endgenerate

endmodule : cpu_sync_edge
`default_nettype wire

// File: rtl/cpu_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_prog_loader
//  Brief    : Serial (SCK/MOSI/CS_N) program loader that writes bytes into the
//             CPU instruction memory and holds the CPU during a frame.
//             Optional checksum outputs enabled by macro LOADER_CSUM_EN.
//  Revision : 1.0
// ============================================================================
module cpu_prog_loader
    import cpu_pkg::*;
#(
    parameter int MEM_SIZE = c_MEM_SIZE_DEFAULT,
    parameter int ADDR_W   = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_SCK,
    input  logic              i_MOSI,
    input  logic              i_CS_N,
    output logic              o_WE,
    output logic [ADDR_W-1:0] o_WADDR,
    output logic [7:0]        o_WDATA,
    output logic              o_CPU_HOLD,
    output logic              o_ERR,
    output logic [8:0]        o_WCOUNT
`ifdef LOADER_CSUM_EN
    ,
    output logic [7:0]        o_CSUM,
    output logic              o_CSUM_VALID
`endif
);

    localparam logic [8:0]        c_MEM_SIZE9 = 9'(MEM_SIZE);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

    logic w_sck_rise, w_sck_fall, w_sck_level;
    logic w_cs_rise, w_cs_fall, w_cs_level;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_edges;

    cpu_sync_edge #(.STAGES(c_SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sck (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_D     (i_SCK),
        .o_LEVEL (w_sck_level),
        .o_RISE  (w_sck_rise),
        .o_FALL  (w_sck_fall)
    );

    cpu_sync_edge #(.STAGES(c_SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_cs (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_D     (i_CS_N),
        .o_LEVEL (w_cs_level),
        .o_RISE  (w_cs_rise),
        .o_FALL  (w_cs_fall)
    );

    cpu_sync_edge #(.STAGES(c_SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_D     (i_MOSI),
        .o_LEVEL (w_mosi),
        .o_RISE  (w_mosi_rise),
        .o_FALL  (w_mosi_fall)
    );

    assign w_unused_edges = ^{w_sck_level, w_sck_fall, w_cs_rise, w_mosi_rise, w_mosi_fall};

    loader_state_t     r_state;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wdata;
    logic              r_hold;
    logic              r_err;
    logic [8:0]        r_wcount;

    logic [7:0] w_byte;
    logic       w_byte_done;
    logic       w_frame_start;
    logic       w_wr_fire;

    assign w_byte        = {r_shift[6:0], w_mosi};
    assign w_byte_done   = w_sck_rise && (r_bitcnt == 3'd7);
    assign w_frame_start = (r_state == ST_IDLE) && w_cs_fall;
    assign w_wr_fire     = (r_state == ST_DATA) && w_byte_done;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= 8'd0;
            r_hold   <= 1'b0;
            r_err    <= 1'b0;
            r_wcount <= 9'd0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Hold was left high on the exit edge; it drops one cycle into IDLE.
                    r_hold <= 1'b0;
                    if (w_frame_start) begin
                        r_state  <= ST_ADDR;
                        r_bitcnt <= 3'd0;
                        r_wcount <= 9'd0;
                        r_err    <= 1'b0;
                        r_hold   <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (w_cs_level) begin
                        r_state <= ST_IDLE;
                    end else if (w_sck_rise) begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            if ({1'b0, w_byte} < c_MEM_SIZE9) begin
                                r_addr  <= ADDR_W'(w_byte);
                                r_state <= ST_DATA;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= ST_SKIP;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    // A completing byte wins over CS_N; the exit follows next cycle.
                    if (w_wr_fire) begin
                        r_we     <= 1'b1;
                        r_waddr  <= r_addr;
                        r_wdata  <= w_byte;
                        r_addr   <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
                        r_wcount <= sat_inc9(r_wcount);
                        r_bitcnt <= 3'd0;
                    end else if (w_cs_level) begin
                        r_state <= ST_IDLE;
                    end else if (w_sck_rise) begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
                ST_SKIP: begin
                    if (w_cs_level) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_WE       = r_we;
    assign o_WADDR    = r_waddr;
    assign o_WDATA    = r_wdata;
    assign o_CPU_HOLD = r_hold;
    assign o_ERR      = r_err;
    assign o_WCOUNT   = r_wcount;

`ifdef LOADER_CSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_valid;
    logic       w_data_exit;

    assign w_data_exit = (r_state == ST_DATA) && w_cs_level && !w_byte_done;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_csum       <= 8'd0;
            r_csum_valid <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_csum       <= 8'd0;
                r_csum_valid <= 1'b0;
            end else begin
                if (w_wr_fire) begin
                    r_csum <= r_csum ^ w_byte;
                end
                if (w_data_exit) begin
                    r_csum_valid <= 1'b1;
                end
            end
        end
    end

    assign o_CSUM       = r_csum;
    assign o_CSUM_VALID = r_csum_valid;
`else
    // Checksum outputs are not built in this configuration.
`endif

endmodule : cpu_prog_loader
`default_nettype wire

// File: tb/tb_cpu_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_prog_loader
//  Brief    : Directed self-checking bench for cpu_prog_loader (256-byte and
//             16-byte instances sharing the serial pins).
//  Revision : 1.0
// ============================================================================
module tb_cpu_prog_loader;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck   = 1'b0;
    logic       mosi  = 1'b0;
    logic       cs_n  = 1'b1;

    logic       we_a, hold_a, err_a;
    logic [7:0] waddr_a, wdata_a;
    logic [8:0] wcount_a;
    logic       we_b, hold_b, err_b;
    logic [3:0] waddr_b;
    logic [7:0] wdata_b;
    logic [8:0] wcount_b;
`ifdef LOADER_CSUM_EN
    logic [7:0] csum_a, csum_b;
    logic       csv_a, csv_b;
`endif

    always #5 clk = ~clk;

    cpu_prog_loader #(.MEM_SIZE(256), .ADDR_W(8)) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_SCK(sck), .i_MOSI(mosi), .i_CS_N(cs_n),
        .o_WE(we_a), .o_WADDR(waddr_a), .o_WDATA(wdata_a), .o_CPU_HOLD(hold_a),
        .o_ERR(err_a), .o_WCOUNT(wcount_a)
`ifdef LOADER_CSUM_EN
        , .o_CSUM(csum_a), .o_CSUM_VALID(csv_a)
`endif
    );

    cpu_prog_loader #(.MEM_SIZE(16), .ADDR_W(4)) dut16 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_SCK(sck), .i_MOSI(mosi), .i_CS_N(cs_n),
        .o_WE(we_b), .o_WADDR(waddr_b), .o_WDATA(wdata_b), .o_CPU_HOLD(hold_b),
        .o_ERR(err_b), .o_WCOUNT(wcount_b)
`ifdef LOADER_CSUM_EN
        , .o_CSUM(csum_b), .o_CSUM_VALID(csv_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] log_a[$];
    logic [15:0] log_b[$];

    always @(negedge clk) begin
        if (we_a === 1'b1) log_a.push_back({waddr_a, wdata_a});
        if (we_b === 1'b1) log_b.push_back({4'h0, waddr_b, wdata_b});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        sck  = 1'b0;
        tick(4);
        sck  = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic frame_begin();
        sck  = 1'b0;
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        sck  = 1'b0;
        tick(4);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic test_reset();
        logic [15:0] exp_w;
        rst_n = 1'b0;
        tick(2);
        n_vec++;
        if ({we_a, waddr_a, wdata_a} !== 17'd0) begin
            n_err++; $display("FAIL reset_wport got %b/%h/%h want 0/00/00", we_a, waddr_a, wdata_a);
        end
        n_vec++;
        if ({hold_a, err_a, wcount_a} !== 11'd0) begin
            n_err++; $display("FAIL reset_status got hold=%b err=%b cnt=%0d want 0/0/0", hold_a, err_a, wcount_a);
        end
        rst_n = 1'b1;
        tick(2);
        frame_begin();
        for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        n_vec++;
        if (hold_a !== 1'b1) begin
            n_err++; $display("FAIL hold_in_frame got %b want 1", hold_a);
        end
        log_a.delete();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({hold_a, we_a, err_a, wcount_a} !== 12'd0) begin
            n_err++; $display("FAIL midframe_reset got hold=%b we=%b err=%b cnt=%0d want all 0", hold_a, we_a, err_a, wcount_a);
        end
        sck  = 1'b0;
        cs_n = 1'b1;
        tick(6);
        rst_n = 1'b1;
        tick(4);
        n_vec++;
        if (log_a.size() !== 0) begin
            n_err++; $display("FAIL reset_no_write got %0d writes want 0", log_a.size());
        end
        frame_begin();
        send_byte(8'h08);
        send_byte(8'h77);
        frame_end();
        exp_w = 16'h0877;
        n_vec++;
        if (log_a.size() !== 1 || log_a[0] !== exp_w) begin
            n_err++; $display("FAIL post_reset_write got n=%0d first=%h want n=1 %h", log_a.size(),
                              (log_a.size() > 0) ? log_a[0] : 16'hxxxx, exp_w);
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] exp_w[3];
        exp_w = '{16'h0421, 16'h0500, 16'h0613};
        log_a.delete();
        frame_begin();
        send_byte(8'h04);
        send_byte(8'h21);
        send_byte(8'h00);
        send_byte(8'h13);
        sck = 1'b0;
        tick(4);
        cs_n = 1'b1;
        tick(4);
        n_vec++;
        if (hold_a !== 1'b1) begin
            n_err++; $display("FAIL hold_extra_cycle got %b want 1", hold_a);
        end
        tick(1);
        n_vec++;
        if (hold_a !== 1'b0) begin
            n_err++; $display("FAIL hold_release got %b want 0", hold_a);
        end
        tick(4);
        n_vec++;
        if (log_a.size() !== 3) begin
            n_err++; $display("FAIL basic_count got %0d writes want 3", log_a.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < log_a.size()) begin
                n_vec++;
                if (log_a[i] !== exp_w[i]) begin
                    n_err++; $display("FAIL basic_write%0d got %h want %h", i, log_a[i], exp_w[i]);
                end
            end
        end
        n_vec++;
        if (wcount_a !== 9'd3 || err_a !== 1'b0) begin
            n_err++; $display("FAIL basic_status got cnt=%0d err=%b want 3/0", wcount_a, err_a);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w[3];
        exp_w = '{16'hFEAA, 16'hFFBB, 16'h00CC};
        log_a.delete();
        frame_begin();
        send_byte(8'hFE);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        frame_end();
        n_vec++;
        if (log_a.size() !== 3) begin
            n_err++; $display("FAIL wrap_count got %0d writes want 3", log_a.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < log_a.size()) begin
                n_vec++;
                if (log_a[i] !== exp_w[i]) begin
                    n_err++; $display("FAIL wrap_write%0d got %h want %h", i, log_a[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] exp_w[2];
        log_b.delete();
        frame_begin();
        send_byte(8'h10);
        send_byte(8'h55);
        send_byte(8'h66);
        frame_end();
        n_vec++;
        if (err_b !== 1'b1 || wcount_b !== 9'd0 || log_b.size() !== 0) begin
            n_err++; $display("FAIL oor_16 got err=%b cnt=%0d writes=%0d want 1/0/0", err_b, wcount_b, log_b.size());
        end
        n_vec++;
        if (err_a !== 1'b0 || wcount_a !== 9'd2) begin
            n_err++; $display("FAIL oor_256 got err=%b cnt=%0d want 0/2", err_a, wcount_a);
        end
        // Last legal address on the 16-byte instance wraps to 0.
        exp_w = '{16'h0F9C, 16'h003E};
        log_b.delete();
        frame_begin();
        send_byte(8'h0F);
        send_byte(8'h9C);
        send_byte(8'h3E);
        frame_end();
        n_vec++;
        if (err_b !== 1'b0 || log_b.size() !== 2) begin
            n_err++; $display("FAIL wrap16_status got err=%b writes=%0d want 0/2", err_b, log_b.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (i < log_b.size()) begin
                n_vec++;
                if (log_b[i] !== exp_w[i]) begin
                    n_err++; $display("FAIL wrap16_write%0d got %h want %h", i, log_b[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_partial_latency();
        logic [7:0] b;
        b = 8'h5A;
        log_a.delete();
        frame_begin();
        send_byte(8'h00);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        mosi = b[0];
        sck  = 1'b0;
        tick(4);
        sck  = 1'b1;
        tick(3);
        n_vec++;
        if (we_a !== 1'b0) begin
            n_err++; $display("FAIL latency_early got we=%b want 0 at 3 cycles", we_a);
        end
        tick(1);
        n_vec++;
        if (we_a !== 1'b1 || waddr_a !== 8'h00 || wdata_a !== 8'h5A) begin
            n_err++; $display("FAIL latency_4 got we=%b addr=%h data=%h want 1/00/5a", we_a, waddr_a, wdata_a);
        end
        tick(1);
        n_vec++;
        if (we_a !== 1'b0) begin
            n_err++; $display("FAIL we_one_cycle got we=%b want 0", we_a);
        end
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        frame_end();
        n_vec++;
        if (log_a.size() !== 1 || wcount_a !== 9'd1) begin
            n_err++; $display("FAIL partial_discard got writes=%0d cnt=%0d want 1/1", log_a.size(), wcount_a);
        end
    endtask

    task automatic test_cs_on_last_bit();
        logic [7:0] b;
        b = 8'hC3;
        log_a.delete();
        frame_begin();
        send_byte(8'h30);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        mosi = b[0];
        sck  = 1'b0;
        tick(4);
        sck  = 1'b1;
        cs_n = 1'b1;
        tick(10);
        sck  = 1'b0;
        tick(4);
        n_vec++;
        if (log_a.size() !== 1 || (log_a.size() > 0 && log_a[0] !== 16'h30C3)) begin
            n_err++; $display("FAIL cs_last_bit got writes=%0d first=%h want 1 30c3", log_a.size(),
                              (log_a.size() > 0) ? log_a[0] : 16'hxxxx);
        end
        n_vec++;
        if (hold_a !== 1'b0 || wcount_a !== 9'd1) begin
            n_err++; $display("FAIL cs_last_status got hold=%b cnt=%0d want 0/1", hold_a, wcount_a);
        end
    endtask

`ifdef LOADER_CSUM_EN
    task automatic test_csum();
        frame_begin();
        send_byte(8'h40);
        send_byte(8'h13);
        send_byte(8'h34);
        send_byte(8'h45);
        frame_end();
        n_vec++;
        if (csum_a !== 8'h62 || csv_a !== 1'b1) begin
            n_err++; $display("FAIL csum_value got %h valid=%b want 62/1", csum_a, csv_a);
        end
        frame_begin();
        n_vec++;
        if (csum_a !== 8'h00 || csv_a !== 1'b0) begin
            n_err++; $display("FAIL csum_clear got %h valid=%b want 00/0", csum_a, csv_a);
        end
        send_byte(8'h00);
        frame_end();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_wrap();
        test_out_of_range();
        test_partial_latency();
        test_cs_on_last_bit();
`ifdef LOADER_CSUM_EN
        test_csum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_cpu_prog_loader
`default_nettype wire
